// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed Booth multiplier / restoring divider holding HI/LO
module mult_div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_mult,
    input  logic              start_div,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic [DATA_W-1:0] HI,
    output logic [DATA_W-1:0] LO,
    output logic              busy,
    output logic              done,
    output logic              div_zero
);
    localparam int CW = $clog2(DATA_W);
    localparam int MSB = DATA_W - 1;
    typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;
    state_t state_q, state_d;
    // acc: Booth upper accumulator or division remainder (one guard bit)
    // wrk: Booth multiplier/low product or dividend shifting into quotient
    logic [DATA_W:0]   acc_q, acc_d;
    logic [DATA_W-1:0] wrk_q, wrk_d, m_q, m_d, hi_q, hi_d, lo_q, lo_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              qb_q, qb_d, div_q, div_d, qneg_q, qneg_d, rneg_q, rneg_d;
    logic              busy_q, busy_d, done_q, done_d, dz_q, dz_d;
    logic [DATA_W:0]   mext, bsum, shifted, trial;
    logic              last;
    assign mext    = {m_q[MSB], m_q};
    assign bsum    = ({wrk_q[0], qb_q} == 2'b01) ? acc_q + mext :
                     ({wrk_q[0], qb_q} == 2'b10) ? acc_q - mext : acc_q;
    assign shifted = {acc_q[MSB:0], wrk_q[MSB]};
    assign trial   = shifted - {1'b0, m_q};
    assign last    = cnt_q == CW'(DATA_W - 1);
    assign HI       = hi_q;
    assign LO       = lo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    // Next-state logic: operand capture, one Booth/restoring step per cycle, result write-back
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        wrk_d   = wrk_q;
        m_d     = m_q;
        qb_d    = qb_q;
        div_d   = div_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;
        busy_d  = (state_q == MULT) || (state_q == DIV);
        case (state_q)
            IDLE: begin
                if (start_mult) begin
                    state_d = MULT;
                    acc_d   = '0;
                    wrk_d   = B;
                    m_d     = A;
                    qb_d    = 1'b0;
                    div_d   = 1'b0;
                    cnt_d   = '0;
                end else if (start_div && B == '0) begin
                    dz_d = 1'b1;
                end else if (start_div) begin
                    state_d = DIV;
                    acc_d   = '0;
                    wrk_d   = A[MSB] ? -A : A;
                    m_d     = B[MSB] ? -B : B;
                    div_d   = 1'b1;
                    qneg_d  = A[MSB] ^ B[MSB];
                    rneg_d  = A[MSB];
                    cnt_d   = '0;
                end
            end
            MULT: begin
                acc_d   = {bsum[DATA_W], bsum[DATA_W:1]};
                wrk_d   = {bsum[0], wrk_q[MSB:1]};
                qb_d    = wrk_q[0];
                cnt_d   = cnt_q + 1'b1;
                state_d = last ? FINISH : MULT;
            end
            DIV: begin
                acc_d   = trial[DATA_W] ? shifted : trial;
                wrk_d   = {wrk_q[MSB-1:0], ~trial[DATA_W]};
                cnt_d   = cnt_q + 1'b1;
                state_d = last ? FINISH : DIV;
            end
            FINISH: begin
                hi_d    = (div_q && rneg_q) ? -acc_q[MSB:0] : acc_q[MSB:0];
                lo_d    = (div_q && qneg_q) ? -wrk_q : wrk_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            wrk_q   <= '0;
            m_q     <= '0;
            qb_q    <= 1'b0;
            div_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            wrk_q   <= wrk_d;
            m_q     <= m_d;
            qb_q    <= qb_d;
            div_q   <= div_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: arithmetic reference model plus directed vectors for mult_div_unit
module tb_mult_div_unit;
    localparam int W = 32;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start_mult = 1'b0;
    logic         start_div = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [W-1:0] HI, LO;
    logic         busy, done, div_zero;
    int checks = 0;
    int failures = 0;
    mult_div_unit #(.DATA_W(W)) dut (
        .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
        .A(A), .B(B), .HI(HI), .LO(LO), .busy(busy), .done(done), .div_zero(div_zero)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    // Reference model: results from plain signed arithmetic, timing from a countdown
    logic [W-1:0] e_hi, e_lo, p_hi, p_lo;
    logic         e_busy, e_done, e_dz;
    bit           armed = 0;
    int           rem = 0;
    longint       p, q, r;
    always @(posedge clk) begin
        armed = 1;
        if (reset) begin
            e_hi = '0; e_lo = '0; e_busy = 0; e_done = 0; e_dz = 0; rem = 0;
        end else begin
            e_done = 0;
            e_dz = 0;
            if (rem > 0) begin
                rem--;
                e_busy = rem != 0;
                if (rem == 0) begin
                    e_done = 1; e_hi = p_hi; e_lo = p_lo;
                end
            end else if (start_mult) begin
                p = longint'($signed(A)) * longint'($signed(B));
                p_hi = p[63:32]; p_lo = p[31:0]; rem = W + 1;
            end else if (start_div) begin
                if (B == '0) e_dz = 1;
                else begin
                    q = longint'($signed(A)) / longint'($signed(B));
                    r = longint'($signed(A)) % longint'($signed(B));
                    p_hi = r[31:0]; p_lo = q[31:0]; rem = W + 1;
                end
            end
        end
    end
    always @(negedge clk) begin
        if (armed) begin
            chk("cyc_hi", {32'h0, HI}, {32'h0, e_hi});
            chk("cyc_lo", {32'h0, LO}, {32'h0, e_lo});
            chk("cyc_busy", {63'h0, busy}, {63'h0, e_busy});
            chk("cyc_done", {63'h0, done}, {63'h0, e_done});
            chk("cyc_div_zero", {63'h0, div_zero}, {63'h0, e_dz});
        end
    end
    int nbusy;
    // Start one operation, optionally pulse start_div mid-run, then wait for done
    task automatic run_op(input bit m, input bit d, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int inj, input string name);
        bit seen = 0;
        @(posedge clk); #2;
        start_mult = m; start_div = d; A = a; B = b;
        @(posedge clk); #2;
        start_mult = 0; start_div = 0; A = $urandom; B = $urandom;
        nbusy = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) seen = 1;
            start_div = (i == inj);
            B = (i == inj) ? 32'd1 : B;
        end
        start_div = 0;
        chk({name, "_done_seen"}, {63'h0, seen}, 64'h1);
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #2 reset = 0;
        @(negedge clk);
        chk("reset_hilo", {HI, LO}, 64'h0);
        chk("reset_flags", {61'h0, busy, done, div_zero}, 64'h0);
        run_op(1, 0, 32'd7, -32'sd3, -1, "mul7x-3");
        chk("mul7x-3", {HI, LO}, 64'hFFFFFFFF_FFFFFFEB);
        chk("mul7x-3_busy_cycles", 64'(nbusy), 64'd32);
        run_op(1, 0, 32'h80000000, 32'h80000000, -1, "mulmin");
        chk("mulmin", {HI, LO}, 64'h40000000_00000000);
        run_op(0, 1, -32'sd7, 32'd2, -1, "div-7/2");
        chk("div-7/2", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
        run_op(0, 1, 32'd7, -32'sd2, -1, "div7/-2");
        chk("div7/-2", {HI, LO}, 64'h00000001_FFFFFFFD);
        run_op(0, 1, 32'd100, 32'd7, -1, "div100/7");
        chk("div100/7", {HI, LO}, 64'h00000002_0000000E);
        run_op(0, 1, -32'sd100, 32'd7, -1, "div-100/7");
        chk("div-100/7", {HI, LO}, 64'hFFFFFFFE_FFFFFFF2);
        run_op(1, 0, -32'sd1, -32'sd1, -1, "mul-1x-1");
        chk("mul-1x-1", {HI, LO}, 64'h00000000_00000001);
        run_op(1, 0, 32'd3, 32'd4, -1, "mul3x4");
        chk("mul3x4", {HI, LO}, 64'h00000000_0000000C);
        @(posedge clk); #2;
        start_div = 1; A = 32'd5; B = 32'd0;
        @(posedge clk); #2;
        start_div = 0;
        @(negedge clk);
        chk("divzero_pulse", {62'h0, div_zero, done}, 64'h2);
        repeat (5) @(negedge clk);
        chk("divzero_hilo_kept", {HI, LO}, 64'h00000000_0000000C);
        run_op(1, 1, 32'd6, 32'd3, 5, "both_starts");
        chk("both_starts", {HI, LO}, 64'h00000000_00000012);
        repeat (40) @(negedge clk);
        chk("no_second_done_hilo", {HI, LO}, 64'h00000000_00000012);
        @(posedge clk); #2;
        start_div = 1; A = 32'd100; B = 32'd7;
        @(posedge clk); #2;
        start_div = 0;
        repeat (10) @(negedge clk);
        reset = 1;
        @(negedge clk);
        chk("abort_hilo", {HI, LO}, 64'h0);
        chk("abort_busy", {63'h0, busy}, 64'h0);
        reset = 0;
        repeat (40) @(negedge clk);
        chk("abort_no_done_hilo", {HI, LO}, 64'h0);
        run_op(0, 1, 32'h80000000, 32'hFFFFFFFF, -1, "divmin/-1");
        chk("divmin/-1", {HI, LO}, 64'h00000000_80000000);
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
